x86_bus_responder: RTL

- Target side of the x86cpu memory bus. Answers every CPU byte access on address/i_data/o_data/wr and paces the core through its `locked` execute-enable.
- Decodes a 20-bit real-mode address into three regions: writable RAM, write-protected BIOS ROM and an unmapped hole. Drives an external async 8-bit SRAM/flash bus with programmable wait states.
- Sits between x86cpu and the board memory pins in the top level.

---
 rtl/x86_bus_pkg.sv | 21 ++
 rtl/x86_bus_decode.sv | 29 ++
 rtl/x86_bus_responder.sv | 129 ++++++++++++
 3 files changed

// File: rtl/x86_bus_pkg.sv
// Shared types and constants for the x86 memory-bus responder and its address decoder.
// Holds the FSM states, the memory regions, the unmapped read value and the default region bounds.
package x86_bus_pkg;

  typedef enum logic [1:0] {
    ST_SETUP = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_ROM  = 2'd1,
    REG_NONE = 2'd2
  } region_t;

  localparam logic [7:0]  UNMAPPED_RDATA = 8'hFF;
  localparam logic [19:0] DEF_RAM_TOP    = 20'hA0000;
  localparam logic [19:0] DEF_ROM_BASE   = 20'hF0000;

endpackage

// File: rtl/x86_bus_decode.sv
// Real-mode address decoder: 20-bit address -> region and wait-state count.
// Purely combinational (zero latency); it has no flow control of its own.
module x86_bus_decode
  import x86_bus_pkg::*;
#(
  parameter int unsigned RAM_WAIT = 1,
  parameter int unsigned ROM_WAIT = 3,
  parameter logic [19:0] RAM_TOP  = DEF_RAM_TOP,
  parameter logic [19:0] ROM_BASE = DEF_ROM_BASE
) (
  input  logic [19:0] addr_i,
  output region_t     region_o,
  output logic [3:0]  wait_o
);

  // The gap between RAM_TOP and ROM_BASE is the hole; it gets no wait states.
  always_comb begin
    region_o = REG_NONE;
    wait_o   = 4'd0;
    if (addr_i < RAM_TOP) begin
      region_o = REG_RAM;
      wait_o   = RAM_WAIT[3:0];
    end else if (addr_i >= ROM_BASE) begin
      region_o = REG_ROM;
      wait_o   = ROM_WAIT[3:0];
    end
  end

endmodule

// File: rtl/x86_bus_responder.sv
// x86cpu bus target driving an async 8-bit SRAM/flash bus; an access takes wait+3 cycles.
// The CPU is back-pressured by holding locked low until the one-cycle DONE pulse.
module x86_bus_responder
  import x86_bus_pkg::*;
#(
  parameter int unsigned RAM_WAIT = 1,
  parameter int unsigned ROM_WAIT = 3,
  parameter logic [19:0] ROM_BASE = DEF_ROM_BASE,
  parameter logic [19:0] RAM_TOP  = DEF_RAM_TOP
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [19:0] address,
  input  logic [7:0]  cpu_wdata,
  input  logic        wr,
  output logic [7:0]  cpu_rdata,
  output logic        locked,
  output logic [19:0] mem_addr,
  output logic [7:0]  mem_dq_o,
  input  logic [7:0]  mem_dq_i,
  output logic        mem_dq_oe,
  output logic        mem_ce_n,
  output logic        rom_ce_n,
  output logic        mem_oe_n,
  output logic        mem_we_n
);

  region_t     dec_region;
  logic [3:0]  dec_wait;

  state_t      state_q;
  region_t     region_q;
  logic [3:0]  cnt_q;
  logic        wr_q;
  logic        locked_q;
  logic [7:0]  cpu_rdata_q;
  logic [19:0] mem_addr_q;
  logic [7:0]  mem_dq_o_q;
  logic        mem_dq_oe_q;
  logic        mem_ce_n_q;
  logic        rom_ce_n_q;
  logic        mem_oe_n_q;
  logic        mem_we_n_q;

  logic        ram_wr_d;
  logic        rom_rd_d;

  x86_bus_decode #(
    .RAM_WAIT (RAM_WAIT),
    .ROM_WAIT (ROM_WAIT),
    .RAM_TOP  (RAM_TOP),
    .ROM_BASE (ROM_BASE)
  ) u_decode (
    .addr_i   (address),
    .region_o (dec_region),
    .wait_o   (dec_wait)
  );

  // ROM and the hole never see a write strobe; ROM is only selected for reads.
  assign ram_wr_d = wr && (dec_region == REG_RAM);
  assign rom_rd_d = !wr && (dec_region == REG_ROM);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_SETUP;
      region_q    <= REG_NONE;
      cnt_q       <= 4'd0;
      wr_q        <= 1'b0;
      locked_q    <= 1'b0;
      cpu_rdata_q <= 8'h00;
      mem_addr_q  <= 20'h00000;
      mem_dq_o_q  <= 8'h00;
      mem_dq_oe_q <= 1'b0;
      mem_ce_n_q  <= 1'b1;
      rom_ce_n_q  <= 1'b1;
      mem_oe_n_q  <= 1'b1;
      mem_we_n_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_SETUP: begin
          mem_addr_q  <= address;
          mem_dq_o_q  <= cpu_wdata;
          wr_q        <= wr;
          region_q    <= dec_region;
          cnt_q       <= dec_wait;
          mem_ce_n_q  <= !(dec_region == REG_RAM);
          rom_ce_n_q  <= !rom_rd_d;
          mem_oe_n_q  <= wr;
          mem_we_n_q  <= !ram_wr_d;
          mem_dq_oe_q <= ram_wr_d;
          state_q     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q    <= ST_DONE;
            locked_q   <= 1'b1;
            mem_we_n_q <= 1'b1;
            mem_oe_n_q <= 1'b1;
            if (!wr_q) begin
              cpu_rdata_q <= (region_q == REG_NONE) ? UNMAPPED_RDATA : mem_dq_i;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_DONE: begin
          // Address, data and select were held through DONE for write hold time.
          locked_q    <= 1'b0;
          mem_ce_n_q  <= 1'b1;
          rom_ce_n_q  <= 1'b1;
          mem_dq_oe_q <= 1'b0;
          state_q     <= ST_SETUP;
        end
        default: state_q <= ST_SETUP;
      endcase
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign locked    = locked_q;
  assign mem_addr  = mem_addr_q;
  assign mem_dq_o  = mem_dq_o_q;
  assign mem_dq_oe = mem_dq_oe_q;
  assign mem_ce_n  = mem_ce_n_q;
  assign rom_ce_n  = rom_ce_n_q;
  assign mem_oe_n  = mem_oe_n_q;
  assign mem_we_n  = mem_we_n_q;

endmodule
